// File: rtl/instr_register_calc.sv
// ---------------------------------------------------------------------------
// instr_register_calc
//   Parametrised instruction register with a one-stage arithmetic pipeline.
//   A write is captured into stage S1 on one edge; the opcode result is
//   computed from S1 and committed with the instruction on the next edge.
//   Reads are registered and forward S1 when it targets the read location.
//
// Ports
//   clk, reset_n                : clock, synchronous active-low reset
//   load_en, write_pointer,
//   opcode, operand_a/_b        : write request and instruction fields
//   read_en, read_pointer       : read request
//   read_valid, rd_*            : registered read data and flags
//   write_count                 : accepted writes since reset, saturating
// ---------------------------------------------------------------------------
module instr_register_calc #(
   parameter int NUM_REGS  = 32,
   parameter int OP_WIDTH  = 32,
   parameter int RES_WIDTH = 64,
   parameter int PTR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        load_en,
   input  logic [PTR_WIDTH-1:0]        write_pointer,
   input  logic [2:0]                  opcode,
   input  logic signed [OP_WIDTH-1:0]  operand_a,
   input  logic signed [OP_WIDTH-1:0]  operand_b,
   input  logic                        read_en,
   input  logic [PTR_WIDTH-1:0]        read_pointer,
   output logic                        read_valid,
   output logic [2:0]                  rd_opcode,
   output logic signed [OP_WIDTH-1:0]  rd_operand_a,
   output logic signed [OP_WIDTH-1:0]  rd_operand_b,
   output logic signed [RES_WIDTH-1:0] rd_result,
   output logic                        rd_written,
   output logic                        rd_div_by_zero,
   output logic [PTR_WIDTH:0]          write_count
);

   typedef enum logic [2:0] {
      OP_ZERO  = 3'd0,
      OP_PASSA = 3'd1,
      OP_PASSB = 3'd2,
      OP_ADD   = 3'd3,
      OP_SUB   = 3'd4,
      OP_MULT  = 3'd5,
      OP_DIV   = 3'd6,
      OP_MOD   = 3'd7
   } opcode_t;

   localparam logic [PTR_WIDTH:0] MAX_COUNT = (PTR_WIDTH + 1)'(NUM_REGS);
   localparam logic [PTR_WIDTH:0] COUNT_ONE = (PTR_WIDTH + 1)'(1);

   // The full product must fit, otherwise MULT would silently overflow.
   if (RES_WIDTH < 2 * OP_WIDTH) begin : g_bad_res_width
      $error("instr_register_calc: RES_WIDTH must be >= 2*OP_WIDTH");
   end
   if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
      $error("instr_register_calc: NUM_REGS must be a power of 2 and >= 2");
   end

   // Stage S1
   logic                        s1_valid_q, s1_valid_d;
   logic [PTR_WIDTH-1:0]        s1_ptr_q, s1_ptr_d;
   logic [2:0]                  s1_opcode_q, s1_opcode_d;
   logic signed [OP_WIDTH-1:0]  s1_a_q, s1_a_d;
   logic signed [OP_WIDTH-1:0]  s1_b_q, s1_b_d;

   // Storage; contents are qualified by written_q so they need no reset
   logic [2:0]                  mem_opcode_q [NUM_REGS];
   logic signed [OP_WIDTH-1:0]  mem_a_q      [NUM_REGS];
   logic signed [OP_WIDTH-1:0]  mem_b_q      [NUM_REGS];
   logic signed [RES_WIDTH-1:0] mem_result_q [NUM_REGS];
   logic [NUM_REGS-1:0]         written_q, written_d;
   logic [NUM_REGS-1:0]         dbz_q, dbz_d;

   // Read port and counter
   logic                        read_valid_q, read_valid_d;
   logic [2:0]                  rd_opcode_q, rd_opcode_d;
   logic signed [OP_WIDTH-1:0]  rd_a_q, rd_a_d;
   logic signed [OP_WIDTH-1:0]  rd_b_q, rd_b_d;
   logic signed [RES_WIDTH-1:0] rd_result_q, rd_result_d;
   logic                        rd_written_q, rd_written_d;
   logic                        rd_dbz_q, rd_dbz_d;
   logic [PTR_WIDTH:0]          write_count_q, write_count_d;

   // Arithmetic on S1
   logic signed [RES_WIDTH-1:0] a_ext_s, b_ext_s, divisor_s, result_s;
   logic                        b_zero_s, dbz_s, fwd_s;

   // S1 capture: a new request replaces the stage, otherwise it empties.
   always_comb begin
      s1_valid_d  = 1'b0;
      s1_ptr_d    = s1_ptr_q;
      s1_opcode_d = s1_opcode_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      if (load_en) begin
         s1_valid_d  = 1'b1;
         s1_ptr_d    = write_pointer;
         s1_opcode_d = opcode;
         s1_a_d      = operand_a;
         s1_b_d      = operand_b;
      end else begin
         s1_valid_d  = 1'b0;
      end
   end

   // Opcode result from S1; divisor forced to 1 on b==0 so the divider never sees zero.
   always_comb begin
      a_ext_s   = {{(RES_WIDTH - OP_WIDTH){s1_a_q[OP_WIDTH-1]}}, s1_a_q};
      b_ext_s   = {{(RES_WIDTH - OP_WIDTH){s1_b_q[OP_WIDTH-1]}}, s1_b_q};
      b_zero_s  = (s1_b_q == {OP_WIDTH{1'b0}});
      divisor_s = b_zero_s ? {{(RES_WIDTH - 1){1'b0}}, 1'b1} : b_ext_s;
      result_s  = {RES_WIDTH{1'b0}};
      dbz_s     = 1'b0;
      case (opcode_t'(s1_opcode_q))
         OP_ZERO:  result_s = {RES_WIDTH{1'b0}};
         OP_PASSA: result_s = a_ext_s;
         OP_PASSB: result_s = b_ext_s;
         OP_ADD:   result_s = a_ext_s + b_ext_s;
         OP_SUB:   result_s = a_ext_s - b_ext_s;
         OP_MULT:  result_s = a_ext_s * b_ext_s;
         OP_DIV: begin
            if (b_zero_s) begin
               result_s = {RES_WIDTH{1'b0}};
               dbz_s    = 1'b1;
            end else begin
               result_s = a_ext_s / divisor_s;
               dbz_s    = 1'b0;
            end
         end
         OP_MOD: begin
            if (b_zero_s) begin
               result_s = {RES_WIDTH{1'b0}};
               dbz_s    = 1'b1;
            end else begin
               result_s = a_ext_s % divisor_s;
               dbz_s    = 1'b0;
            end
         end
         default: begin
            result_s = {RES_WIDTH{1'b0}};
            dbz_s    = 1'b0;
         end
      endcase
   end

   // Per-entry flags and saturating write counter, updated when S1 commits.
   always_comb begin
      written_d     = written_q;
      dbz_d         = dbz_q;
      write_count_d = write_count_q;
      if (s1_valid_q) begin
         written_d[s1_ptr_q] = 1'b1;
         dbz_d[s1_ptr_q]     = dbz_s;
         if (write_count_q != MAX_COUNT) begin
            write_count_d = write_count_q + COUNT_ONE;
         end else begin
            write_count_d = write_count_q;
         end
      end else begin
         written_d     = written_q;
         dbz_d         = dbz_q;
         write_count_d = write_count_q;
      end
   end

   // Read mux: S1 committing to the same location this edge takes priority over storage.
   always_comb begin
      fwd_s        = s1_valid_q && (s1_ptr_q == read_pointer);
      read_valid_d = read_en;
      rd_opcode_d  = rd_opcode_q;
      rd_a_d       = rd_a_q;
      rd_b_d       = rd_b_q;
      rd_result_d  = rd_result_q;
      rd_written_d = rd_written_q;
      rd_dbz_d     = rd_dbz_q;
      if (read_en) begin
         if (fwd_s) begin
            rd_opcode_d  = s1_opcode_q;
            rd_a_d       = s1_a_q;
            rd_b_d       = s1_b_q;
            rd_result_d  = result_s;
            rd_written_d = 1'b1;
            rd_dbz_d     = dbz_s;
         end else begin
            rd_opcode_d  = mem_opcode_q[read_pointer];
            rd_a_d       = mem_a_q[read_pointer];
            rd_b_d       = mem_b_q[read_pointer];
            rd_result_d  = mem_result_q[read_pointer];
            rd_written_d = written_q[read_pointer];
            rd_dbz_d     = dbz_q[read_pointer];
         end
      end else begin
         read_valid_d = 1'b0;
      end
   end

   // Storage write; suppressed under reset so a pending S1 write is discarded.
   always_ff @(posedge clk) begin
      if (reset_n && s1_valid_q) begin
         mem_opcode_q[s1_ptr_q] <= s1_opcode_q;
         mem_a_q[s1_ptr_q]      <= s1_a_q;
         mem_b_q[s1_ptr_q]      <= s1_b_q;
         mem_result_q[s1_ptr_q] <= result_s;
      end
   end

   // Control state, flags and read port registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid_q    <= 1'b0;
         s1_ptr_q      <= {PTR_WIDTH{1'b0}};
         s1_opcode_q   <= 3'd0;
         s1_a_q        <= {OP_WIDTH{1'b0}};
         s1_b_q        <= {OP_WIDTH{1'b0}};
         written_q     <= {NUM_REGS{1'b0}};
         dbz_q         <= {NUM_REGS{1'b0}};
         write_count_q <= {(PTR_WIDTH + 1){1'b0}};
         read_valid_q  <= 1'b0;
         rd_opcode_q   <= 3'd0;
         rd_a_q        <= {OP_WIDTH{1'b0}};
         rd_b_q        <= {OP_WIDTH{1'b0}};
         rd_result_q   <= {RES_WIDTH{1'b0}};
         rd_written_q  <= 1'b0;
         rd_dbz_q      <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_ptr_q      <= s1_ptr_d;
         s1_opcode_q   <= s1_opcode_d;
         s1_a_q        <= s1_a_d;
         s1_b_q        <= s1_b_d;
         written_q     <= written_d;
         dbz_q         <= dbz_d;
         write_count_q <= write_count_d;
         read_valid_q  <= read_valid_d;
         rd_opcode_q   <= rd_opcode_d;
         rd_a_q        <= rd_a_d;
         rd_b_q        <= rd_b_d;
         rd_result_q   <= rd_result_d;
         rd_written_q  <= rd_written_d;
         rd_dbz_q      <= rd_dbz_d;
      end
   end

   assign read_valid     = read_valid_q;
   assign rd_opcode      = rd_opcode_q;
   assign rd_operand_a   = rd_a_q;
   assign rd_operand_b   = rd_b_q;
   assign rd_result      = rd_result_q;
   assign rd_written     = rd_written_q;
   assign rd_div_by_zero = rd_dbz_q;
   assign write_count    = write_count_q;

endmodule

// File: tb/tb_instr_register_calc.sv
// ---------------------------------------------------------------------------
// tb_instr_register_calc
//   Directed self-checking bench. Main instance uses default parameters; a
//   second small instance (NUM_REGS=4, OP_WIDTH=8, RES_WIDTH=16) covers
//   pointer wrap and narrow arithmetic.
// ---------------------------------------------------------------------------
module tb_instr_register_calc;

   localparam int OPW = 32;
   localparam int RSW = 64;
   localparam int PW  = 5;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                load_en = 1'b0;
   logic [PW-1:0]       write_pointer = '0;
   logic [2:0]          opcode = 3'd0;
   logic signed [OPW-1:0] operand_a = '0;
   logic signed [OPW-1:0] operand_b = '0;
   logic                read_en = 1'b0;
   logic [PW-1:0]       read_pointer = '0;
   logic                read_valid;
   logic [2:0]          rd_opcode;
   logic signed [OPW-1:0] rd_operand_a;
   logic signed [OPW-1:0] rd_operand_b;
   logic signed [RSW-1:0] rd_result;
   logic                rd_written;
   logic                rd_div_by_zero;
   logic [PW:0]         write_count;

   // small instance
   logic                p_load_en = 1'b0;
   logic [1:0]          p_write_pointer = '0;
   logic [2:0]          p_opcode = 3'd0;
   logic signed [7:0]   p_operand_a = '0;
   logic signed [7:0]   p_operand_b = '0;
   logic                p_read_en = 1'b0;
   logic [1:0]          p_read_pointer = '0;
   logic                p_read_valid;
   logic [2:0]          p_rd_opcode;
   logic signed [7:0]   p_rd_operand_a;
   logic signed [7:0]   p_rd_operand_b;
   logic signed [15:0]  p_rd_result;
   logic                p_rd_written;
   logic                p_rd_div_by_zero;
   logic [2:0]          p_write_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instr_register_calc dut (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .write_pointer(write_pointer),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .read_en(read_en), .read_pointer(read_pointer), .read_valid(read_valid),
      .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
      .rd_result(rd_result), .rd_written(rd_written), .rd_div_by_zero(rd_div_by_zero),
      .write_count(write_count)
   );

   instr_register_calc #(.NUM_REGS(4), .OP_WIDTH(8), .RES_WIDTH(16)) dut_small (
      .clk(clk), .reset_n(reset_n), .load_en(p_load_en), .write_pointer(p_write_pointer),
      .opcode(p_opcode), .operand_a(p_operand_a), .operand_b(p_operand_b),
      .read_en(p_read_en), .read_pointer(p_read_pointer), .read_valid(p_read_valid),
      .rd_opcode(p_rd_opcode), .rd_operand_a(p_rd_operand_a), .rd_operand_b(p_rd_operand_b),
      .rd_result(p_rd_result), .rd_written(p_rd_written), .rd_div_by_zero(p_rd_div_by_zero),
      .write_count(p_write_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load(input logic [PW-1:0] ptr, input logic [2:0] op,
                           input logic signed [OPW-1:0] a, input logic signed [OPW-1:0] b);
      load_en = 1'b1; write_pointer = ptr; opcode = op; operand_a = a; operand_b = b;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; load_en = 1'b0; read_en = 1'b0;
      tick(); tick();
      n_checks++;
      if (read_valid !== 1'b0) begin n_errors++; $display("FAIL reset_read_valid: got %0b expected 0", read_valid); end
      n_checks++;
      if (write_count !== 6'd0) begin n_errors++; $display("FAIL reset_write_count: got %0d expected 0", write_count); end
      n_checks++;
      if (rd_written !== 1'b0 || rd_result !== 64'd0) begin n_errors++;
         $display("FAIL reset_rd: got written=%0b result=%0d expected 0/0", rd_written, rd_result); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      set_load(5'd0, 3'd3, 32'sd7, -32'sd3);
      tick();
      load_en = 1'b0;
      tick();
      read_en = 1'b1; read_pointer = 5'd0;
      tick();
      read_en = 1'b0;
      n_checks++;
      if (read_valid !== 1'b1) begin n_errors++; $display("FAIL add_valid: got %0b expected 1", read_valid); end
      n_checks++;
      if (rd_result !== 64'sd4) begin n_errors++; $display("FAIL add_result: got %0d expected 4", rd_result); end
      n_checks++;
      if (rd_written !== 1'b1 || rd_opcode !== 3'd3 || rd_operand_b !== -32'sd3) begin n_errors++;
         $display("FAIL add_fields: got w=%0b op=%0d b=%0d expected 1/3/-3", rd_written, rd_opcode, rd_operand_b); end
      n_checks++;
      if (write_count !== 6'd1) begin n_errors++; $display("FAIL add_count: got %0d expected 1", write_count); end
      tick();
      n_checks++;
      if (read_valid !== 1'b0 || rd_result !== 64'sd4) begin n_errors++;
         $display("FAIL idle_hold: got valid=%0b result=%0d expected 0/4", read_valid, rd_result); end
   endtask

   task automatic test_forward();
      // read at the same edge as the write: not visible
      set_load(5'd5, 3'd5, -32'sd6, 32'sd9);
      read_en = 1'b1; read_pointer = 5'd5;
      tick();
      load_en = 1'b0;
      n_checks++;
      if (read_valid !== 1'b1 || rd_written !== 1'b0) begin n_errors++;
         $display("FAIL same_edge_read: got valid=%0b written=%0b expected 1/0", read_valid, rd_written); end
      // read at the next edge: forwarded from the pipeline stage
      tick();
      read_en = 1'b0;
      n_checks++;
      if (rd_result !== -64'sd54 || rd_written !== 1'b1) begin n_errors++;
         $display("FAIL forward_mult: got result=%0d written=%0b expected -54/1", rd_result, rd_written); end
      n_checks++;
      if (rd_operand_a !== -32'sd6 || write_count !== 6'd2) begin n_errors++;
         $display("FAIL forward_fields: got a=%0d count=%0d expected -6/2", rd_operand_a, write_count); end
   endtask

   task automatic test_divide();
      logic [2:0]            ops  [5] = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6};
      logic signed [OPW-1:0] as   [5] = '{-32'sd7, -32'sd7, 32'sd5, 32'sd9, 32'h8000_0000};
      logic signed [OPW-1:0] bs   [5] = '{32'sd2, 32'sd2, 32'sd0, 32'sd0, -32'sd1};
      logic signed [RSW-1:0] exps [5] = '{-64'sd3, -64'sd1, 64'sd0, 64'sd0, 64'sd2147483648};
      logic                  dbzs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         set_load(5'(10 + i), ops[i], as[i], bs[i]);
         tick();
         load_en = 1'b0; read_en = 1'b1; read_pointer = 5'(10 + i);
         tick();
         read_en = 1'b0;
         n_checks++;
         if (rd_result !== exps[i] || rd_div_by_zero !== dbzs[i]) begin n_errors++;
            $display("FAIL divide_%0d: got result=%0d dbz=%0b expected %0d/%0b", i, rd_result, rd_div_by_zero, exps[i], dbzs[i]); end
      end
      // flag must also come back from storage, not just the forward path
      read_en = 1'b1; read_pointer = 5'd12;
      tick();
      read_en = 1'b0;
      n_checks++;
      if (rd_div_by_zero !== 1'b1 || rd_result !== 64'sd0 || rd_written !== 1'b1) begin n_errors++;
         $display("FAIL dbz_stored: got dbz=%0b result=%0d written=%0b expected 1/0/1", rd_div_by_zero, rd_result, rd_written); end
      read_en = 1'b1; read_pointer = 5'd10;
      tick();
      read_en = 1'b0;
      n_checks++;
      if (rd_div_by_zero !== 1'b0 || rd_result !== -64'sd3) begin n_errors++;
         $display("FAIL div_stored: got dbz=%0b result=%0d expected 0/-3", rd_div_by_zero, rd_result); end
   endtask

   task automatic test_back_to_back();
      logic signed [RSW-1:0] expv;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         set_load(5'(i), 3'd1, 32'(i), 32'sd0);
         tick();
      end
      set_load(5'd1, 3'd1, 32'sd101, 32'sd0); tick();
      set_load(5'd2, 3'd1, 32'sd200, 32'sd0); tick();
      set_load(5'd2, 3'd1, 32'sd201, 32'sd0); tick();
      load_en = 1'b0;
      tick();
      n_checks++;
      if (write_count !== 6'd32) begin n_errors++; $display("FAIL count_saturate: got %0d expected 32", write_count); end
      for (int i = 0; i < 32; i++) begin
         read_en = 1'b1; read_pointer = 5'(i);
         tick();
         expv = (i == 1) ? 64'sd101 : (i == 2) ? 64'sd201 : 64'(i);
         n_checks++;
         if (rd_result !== expv || rd_written !== 1'b1 || read_valid !== 1'b1) begin n_errors++;
            $display("FAIL b2b_loc%0d: got result=%0d written=%0b expected %0d/1", i, rd_result, rd_written, expv); end
      end
      read_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_load(5'd9, 3'd3, 32'sd1, 32'sd1);
      tick();
      load_en = 1'b0; reset_n = 1'b0; read_en = 1'b1; read_pointer = 5'd9;
      tick();
      n_checks++;
      if (read_valid !== 1'b0 || write_count !== 6'd0 || rd_written !== 1'b0) begin n_errors++;
         $display("FAIL reset_mid: got valid=%0b count=%0d written=%0b expected 0/0/0", read_valid, write_count, rd_written); end
      reset_n = 1'b1;
      tick();
      read_en = 1'b0;
      n_checks++;
      if (read_valid !== 1'b1 || rd_written !== 1'b0 || write_count !== 6'd0) begin n_errors++;
         $display("FAIL reset_discard: got valid=%0b written=%0b count=%0d expected 1/0/0", read_valid, rd_written, write_count); end
   endtask

   task automatic test_small_params();
      logic [2:0] seven = 3'd7;
      p_load_en = 1'b1; p_write_pointer = 2'd3; p_opcode = 3'd3; p_operand_a = 8'sd1; p_operand_b = 8'sd2;
      tick();
      p_write_pointer = seven[1:0]; p_opcode = 3'd4; p_operand_a = -8'sd128; p_operand_b = 8'sd127;
      tick();
      p_load_en = 1'b0;
      tick();
      p_read_en = 1'b1; p_read_pointer = 2'd3;
      tick();
      p_read_en = 1'b0;
      n_checks++;
      if (p_rd_result !== -16'sd255 || p_rd_written !== 1'b1) begin n_errors++;
         $display("FAIL small_sub: got result=%0d written=%0b expected -255/1", p_rd_result, p_rd_written); end
      n_checks++;
      if (p_write_count !== 3'd2 || p_rd_opcode !== 3'd4) begin n_errors++;
         $display("FAIL small_fields: got count=%0d op=%0d expected 2/4", p_write_count, p_rd_opcode); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_forward();
      test_divide();
      test_back_to_back();
      test_reset_mid();
      test_small_params();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_register_calc.md
Name: instr_register_calc

Overview:
- Parametrised successor to the instruction register.
- Stores opcode/operand_a/operand_b per location at a configurable depth and operand width.
- Computes the opcode result in a one-stage pipeline and stores it with the instruction.
- Returns a stored entry on a registered, valid-qualified read port with per-entry written and divide-by-zero flags.

Parameters:
- NUM_REGS, 32, number of register locations (power of 2, ≥2).
- OP_WIDTH, 32, signed operand width.
- RES_WIDTH, 64, signed result width; must be ≥ 2*OP_WIDTH (elaboration error otherwise).
- PTR_WIDTH, $clog2(NUM_REGS), pointer width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on posedge.
- reset_n  in  1  synchronous active-low reset.
- load_en  in  1  write request, sampled each posedge.
- write_pointer  in  PTR_WIDTH  write location.
- opcode  in  3  opcode_t: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
- operand_a  in  OP_WIDTH  signed operand.
- operand_b  in  OP_WIDTH  signed operand.
- read_en  in  1  read request.
- read_pointer  in  PTR_WIDTH  read location.
- read_valid  out  1  rd_* outputs valid this cycle.
- rd_opcode  out  3  stored opcode.
- rd_operand_a  out  OP_WIDTH  stored operand_a.
- rd_operand_b  out  OP_WIDTH  stored operand_b.
- rd_result  out  RES_WIDTH  stored signed result.
- rd_written  out  1  location written since reset.
- rd_div_by_zero  out  1  stored result came from DIV/MOD with operand_b=0.
- write_count  out  PTR_WIDTH+1  accepted writes since reset, saturates at NUM_REGS.

Behaviour:
- Reset (reset_n=0 at a posedge):
  - All written flags, pipeline-stage valid, read_valid, all rd_* and write_count clear to 0.
  - Storage array contents need not be cleared; rd_written=0 marks them unwritten.
  - A write sampled in the stage register when reset is applied is discarded.
  - Requests sampled during reset are ignored.
- Write pipeline:
  - Edge N: load_en=1 captures pointer, opcode and operands into stage register S1.
  - Result is computed combinationally from S1.
  - Edge N+1: location is written with fields, result, written=1 and the div_by_zero flag; write_count increments unless saturated.
  - One write per cycle accepted back-to-back; no backpressure.
  - Same location written on consecutive edges: the later write wins.
- Arithmetic, all signed, operands sign-extended to RES_WIDTH:
  - ZERO→0; PASSA→a; PASSB→b; ADD→a+b; SUB→a−b; MULT→a*b (full product, no overflow possible).
  - DIV→a/b, truncated toward zero. a=−2^(OP_WIDTH−1), b=−1 gives +2^(OP_WIDTH−1), representable.
  - MOD→a%b, sign of dividend.
  - DIV or MOD with b=0: result 0 and div_by_zero=1. Otherwise div_by_zero=0.
  - Unknown opcodes are impossible; 3-bit encoding is fully defined.
- Read:
  - read_en=1 sampled at edge M drives rd_* from read_pointer and sets read_valid=1 for the cycle after edge M.
  - read_en=0 at edge M gives read_valid=0; rd_* hold their last values.
- Read/write ordering:
  - A read at edge M reflects every write sampled at edges < M.
  - If S1 holds a write to read_pointer at edge M, the read forwards S1 data and its computed result with written=1.
  - A write sampled at the same edge M as the read is not visible to that read.
- Unwritten location: rd_written=0, rd_div_by_zero=0; other rd_* undefined. The bench checks only rd_written.
- Pointers wrap naturally modulo NUM_REGS; no out-of-range handling needed.

Test Plan:
- Reset then write loc0 ADD a=7 b=−3 → read loc0 two cycles later: read_valid=1, rd_result=4, rd_written=1, write_count=1.
- Forwarding: write loc5 MULT a=−6 b=9 at edge N, read loc5 at edge N+1 → rd_result=−54.
  - Read loc5 at edge N instead → rd_written=0.
- Divide cases:
  - DIV a=−7 b=2 → −3.
  - MOD a=−7 b=2 → −1.
  - DIV a=5 b=0 → rd_result=0, rd_div_by_zero=1.
  - OP_WIDTH=32, DIV a=0x80000000 b=−1 → rd_result=2147483648.
- Back-to-back writes to all 32 locations (PASSA a=i) then 3 extra writes → write_count=32 saturated; every read returns rd_result=i except overwritten locations, which return the latest value.
- Reset mid-operation: load_en=1 at edge N, reset_n=0 at edge N+1, then read that location → rd_written=0, write_count=0, read_valid=0 during reset.
- Parameter sweep NUM_REGS=4, OP_WIDTH=8, RES_WIDTH=16: write loc3 then loc7 (wraps to loc3) SUB a=−128 b=127 → rd_result=−255 at loc3.
